// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback vs. queued MDU results, with RAW/WAW scoreboard.
// Optional macro WB_BYPASS_EN lets an MDU result skip the empty FIFO and write the same cycle.
module wb_port_arbiter #(
    parameter int unsigned DW         = 32,
    parameter int unsigned AW         = 5,
    parameter int unsigned QDEPTH     = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pipe_we,
    input  logic [AW-1:0]        pipe_waddr,
    input  logic [DW-1:0]        pipe_wdata,
    input  logic                 mdu_valid,
    input  logic [AW-1:0]        mdu_waddr,
    input  logic [DW-1:0]        mdu_wdata,
    output logic                 mdu_ready,
    input  logic                 issue_mdu,
    input  logic [AW-1:0]        issue_rd,
    input  logic [AW-1:0]        chk_rs,
    input  logic [AW-1:0]        chk_rt,
    input  logic [AW-1:0]        chk_rd,
    output logic                 stall,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_waddr,
    output logic [DW-1:0]        rf_wdata,
    output logic [(2**AW)-1:0]   pending
);
    localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = $clog2(STARVE_MAX) + 1;
    localparam logic [CW-1:0] QD    = CW'(QDEPTH);
    localparam logic [SW-1:0] SMAX1 = SW'(STARVE_MAX - 1);

    typedef enum logic [1:0] {IDLE, WAIT, FORCE} state_t;

    logic [AW-1:0]       q_addr [QDEPTH];
    logic [DW-1:0]       q_data [QDEPTH];
    logic [PW-1:0]       rd_ptr, wr_ptr;
    logic [CW-1:0]       count, count_nx;
    state_t              state;
    logic [SW-1:0]       starve;
    logic [AW-1:0]       last_addr;
    logic [DW-1:0]       last_data;
    logic [(2**AW)-1:0]  pend_nx;

    logic pipe_eff, fifo_empty, pop, push, bypass;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;

    assign pipe_eff   = pipe_we && (pipe_waddr != '0);
    assign fifo_empty = (count == '0);
    assign head_addr  = q_addr[rd_ptr];
    assign head_data  = q_data[rd_ptr];
    assign pop        = !pipe_eff && !fifo_empty;
    assign mdu_ready  = (count < QD);

`ifdef WB_BYPASS_EN
    assign bypass = fifo_empty && !pipe_eff && mdu_valid;
`else
    assign bypass = 1'b0;
`endif

    assign push     = mdu_valid && mdu_ready && !bypass;
    assign count_nx = count + CW'(push) - CW'(pop);

    // Address/data hold the last value actually written while the port is idle.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = last_addr;
        rf_wdata = last_data;
        if (pipe_eff) begin
            rf_we    = 1'b1;
            rf_waddr = pipe_waddr;
            rf_wdata = pipe_wdata;
        end else if (pop) begin
            if (head_addr != '0) begin
                rf_we    = 1'b1;
                rf_waddr = head_addr;
                rf_wdata = head_data;
            end
        end else if (bypass && (mdu_waddr != '0)) begin
            rf_we    = 1'b1;
            rf_waddr = mdu_waddr;
            rf_wdata = mdu_wdata;
        end
    end

    // Clears are applied before the set so a same-cycle issue to the popped register stays pending.
    always_comb begin
        pend_nx = pending;
        if (pop)
            pend_nx[head_addr] = 1'b0;
        if (bypass)
            pend_nx[mdu_waddr] = 1'b0;
        if (issue_mdu && (issue_rd != '0))
            pend_nx[issue_rd] = 1'b1;
        pend_nx[0] = 1'b0;
    end

    assign stall = pending[chk_rs] | pending[chk_rt] | pending[chk_rd] | (state == FORCE);

    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[wr_ptr] <= mdu_waddr;
            q_data[wr_ptr] <= mdu_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            pending   <= '0;
            last_addr <= '0;
            last_data <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count   <= count_nx;
            pending <= pend_nx;
            if (rf_we) begin
                last_addr <= rf_waddr;
                last_data <= rf_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            starve <= '0;
        end else begin
            case (state)
                IDLE: begin
                    starve <= '0;
                    if (count_nx != '0)
                        state <= WAIT;
                end
                WAIT: begin
                    if (count_nx == '0) begin
                        state  <= IDLE;
                        starve <= '0;
                    end else if (pop) begin
                        starve <= '0;
                    end else if (pipe_eff) begin
                        if (starve == SMAX1)
                            state <= FORCE;
                        else
                            starve <= starve + 1'b1;
                    end
                end
                FORCE: begin
                    if (pop) begin
                        starve <= '0;
                        state  <= (count_nx == '0) ? IDLE : WAIT;
                    end
                end
                default: begin
                    state  <= IDLE;
                    starve <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed vector table, hand-written corner sequences, random vs. reference model.
module tb_wb_port_arbiter;
    localparam int STARVE = 4;
    localparam int DEPTH  = 2;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipe_we, mdu_valid, issue_mdu;
    logic [4:0]  pipe_waddr, mdu_waddr, issue_rd, chk_rs, chk_rt, chk_rd;
    logic [31:0] pipe_wdata, mdu_wdata;
    logic        mdu_ready, stall, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata, pending;

    int pass_cnt = 0;
    int total    = 0;

    wb_port_arbiter #(.DW(32), .AW(5), .QDEPTH(DEPTH), .STARVE_MAX(STARVE)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
        .mdu_valid(mdu_valid), .mdu_waddr(mdu_waddr), .mdu_wdata(mdu_wdata),
        .mdu_ready(mdu_ready),
        .issue_mdu(issue_mdu), .issue_rd(issue_rd),
        .chk_rs(chk_rs), .chk_rt(chk_rt), .chk_rd(chk_rd),
        .stall(stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pending(pending)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pwe; logic [4:0] pa; logic [31:0] pd;
        logic        mv;  logic [4:0] ma; logic [31:0] md;
        logic        im;  logic [4:0] ir;
        logic [4:0]  rs, rt, rd;
        logic        e_we; logic [4:0] e_a; logic [31:0] e_d;
        logic        e_rdy; logic e_stall; logic [31:0] e_pend;
    } vec_t;

    typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else
            pass_cnt++;
    endtask

    task automatic set_in(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                          input logic mv, input logic [4:0] ma, input logic [31:0] md,
                          input logic im, input logic [4:0] ir,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        pipe_we = pwe; pipe_waddr = pa; pipe_wdata = pd;
        mdu_valid = mv; mdu_waddr = ma; mdu_wdata = md;
        issue_mdu = im; issue_rd = ir;
        chk_rs = rs; chk_rt = rt; chk_rd = rd;
    endtask

    task automatic do_reset();
        @(negedge clk);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Directed cycle-by-cycle table (queued path, no bypass)
    task automatic run_table();
        vec_t tbl[12];
        tbl[0]  = '{0,0,0,         0,0,0,          1,7, 0,0,0, 0,0,0,              1,0,32'h0};
        tbl[1]  = '{0,0,0,         0,0,0,          0,0, 7,0,0, 0,0,0,              1,1,32'h80};
        tbl[2]  = '{0,0,0,         1,7,32'h1234,   0,0, 7,0,0, 0,0,0,              1,1,32'h80};
        tbl[3]  = '{0,0,0,         0,0,0,          0,0, 7,0,0, 1,7,32'h1234,       1,1,32'h80};
        tbl[4]  = '{0,0,0,         0,0,0,          0,0, 7,0,0, 0,7,32'h1234,       1,0,32'h0};
        tbl[5]  = '{1,0,32'hFF,    1,9,32'hA5,     1,9, 0,0,0, 0,7,32'h1234,       1,0,32'h0};
        tbl[6]  = '{1,0,32'hFF,    0,0,0,          0,0, 0,9,0, 1,9,32'hA5,         1,1,32'h200};
        tbl[7]  = '{0,0,0,         0,0,0,          0,0, 0,0,0, 0,9,32'hA5,         1,0,32'h0};
        tbl[8]  = '{0,0,0,         1,4,32'h44,     1,4, 0,0,0, 0,9,32'hA5,         1,0,32'h0};
        tbl[9]  = '{0,0,0,         0,0,0,          1,4, 0,0,0, 1,4,32'h44,         1,0,32'h10};
        tbl[10] = '{0,0,0,         0,0,0,          0,0, 0,0,4, 0,4,32'h44,         1,1,32'h10};
        tbl[11] = '{1,2,32'h22,    0,0,0,          0,0, 0,0,4, 1,2,32'h22,         1,1,32'h10};
        do_reset();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            set_in(tbl[i].pwe, tbl[i].pa, tbl[i].pd, tbl[i].mv, tbl[i].ma, tbl[i].md,
                   tbl[i].im, tbl[i].ir, tbl[i].rs, tbl[i].rt, tbl[i].rd);
            #1;
            chk($sformatf("tbl%0d rf_we", i),    32'(rf_we),     32'(tbl[i].e_we));
            chk($sformatf("tbl%0d rf_waddr", i), 32'(rf_waddr),  32'(tbl[i].e_a));
            chk($sformatf("tbl%0d rf_wdata", i), rf_wdata,       tbl[i].e_d);
            chk($sformatf("tbl%0d mdu_ready", i),32'(mdu_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d stall", i),    32'(stall),     32'(tbl[i].e_stall));
            chk($sformatf("tbl%0d pending", i),  pending,        tbl[i].e_pend);
        end
    endtask

    task automatic seq_async_reset();
        do_reset();
        @(negedge clk); set_in(1, 1, 32'h1, 1, 10, 32'hA, 1, 5, 0, 0, 0);
        @(negedge clk); set_in(1, 1, 32'h1, 1, 11, 32'hB, 0, 0, 0, 0, 0);
        @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0);
        #1;
        chk("prerst pending", pending, 32'h20);
        chk("prerst ready", 32'(mdu_ready), 32'd0);
        chk("prerst rf_we", 32'(rf_we), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rst pending", pending, 32'h0);
        chk("rst ready", 32'(mdu_ready), 32'd1);
        chk("rst stall", 32'(stall), 32'd0);
        chk("rst rf_we", 32'(rf_we), 32'd0);
        chk("rst rf_waddr", 32'(rf_waddr), 32'd0);
        #1 rst = 1'b0;
    endtask

    task automatic seq_starve();
        do_reset();
        @(negedge clk); set_in(1, 1, 32'h1, 1, 3, 32'h33, 0, 0, 0, 0, 0);
        #1 chk("stv push rf_waddr", 32'(rf_waddr), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); set_in(1, 1, 32'h1, 0, 0, 0, 0, 0, 0, 0, 0);
            #1;
            chk($sformatf("stv win%0d rf_waddr", i), 32'(rf_waddr), 32'd1);
            chk($sformatf("stv win%0d stall", i), 32'(stall), 32'd0);
        end
        @(negedge clk); set_in(1, 1, 32'h1, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("stv force stall", 32'(stall), 32'd1);
        @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("stv drain rf_we", 32'(rf_we), 32'd1);
        chk("stv drain rf_waddr", 32'(rf_waddr), 32'd3);
        chk("stv drain rf_wdata", rf_wdata, 32'h33);
        @(negedge clk);
        #1;
        chk("stv after stall", 32'(stall), 32'd0);
        chk("stv after rf_we", 32'(rf_we), 32'd0);
    endtask

    task automatic seq_full();
        do_reset();
        @(negedge clk); set_in(1, 1, 32'h1, 1, 10, 32'hA0, 0, 0, 0, 0, 0);
        #1 chk("full c0 ready", 32'(mdu_ready), 32'd1);
        @(negedge clk); set_in(1, 1, 32'h1, 1, 11, 32'hB0, 0, 0, 0, 0, 0);
        #1 chk("full c1 ready", 32'(mdu_ready), 32'd1);
        @(negedge clk); set_in(1, 1, 32'h1, 1, 12, 32'hC0, 0, 0, 0, 0, 0);
        #1 chk("full c2 ready", 32'(mdu_ready), 32'd0);
        @(negedge clk); set_in(0, 0, 0, 1, 12, 32'hC0, 0, 0, 0, 0, 0);
        #1;
        chk("full c3 ready", 32'(mdu_ready), 32'd0);
        chk("full c3 rf_waddr", 32'(rf_waddr), 32'd10);
        chk("full c3 rf_wdata", rf_wdata, 32'hA0);
        @(negedge clk);
        #1;
        chk("full c4 ready", 32'(mdu_ready), 32'd1);
        chk("full c4 rf_waddr", 32'(rf_waddr), 32'd11);
        chk("full c4 rf_wdata", rf_wdata, 32'hB0);
        @(negedge clk); set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("full c5 rf_we", 32'(rf_we), 32'd1);
        chk("full c5 rf_waddr", 32'(rf_waddr), 32'd12);
        chk("full c5 rf_wdata", rf_wdata, 32'hC0);
        @(negedge clk);
        #1;
        chk("full c6 rf_we", 32'(rf_we), 32'd0);
        chk("full c6 ready", 32'(mdu_ready), 32'd1);
    endtask

    // Reference model: queue of results, bit-array scoreboard, count of consecutive losses
    task automatic run_random(input int ncyc);
        ent_t        q[$];
        logic [31:0] m_pend = '0;
        logic [4:0]  last_a = '0;
        logic [31:0] last_d = '0;
        int          losses = 0;
        bit          forced = 0;
        do_reset();
        for (int c = 0; c < ncyc; c++) begin
            bit peff, empty, byp, popv, pushv, rdy, e_we, e_stall;
            logic [4:0]  e_a;
            logic [31:0] e_d;
            ent_t        e;
            @(negedge clk);
            set_in(($urandom % 4) != 0, 5'($urandom % 8), $urandom,
                   ($urandom % 5) < 2, 5'($urandom % 8), $urandom,
                   ($urandom % 10) < 3, 5'($urandom % 8),
                   5'($urandom % 8), 5'($urandom % 8), 5'($urandom % 8));
            peff  = pipe_we && (pipe_waddr != 0);
            empty = (q.size() == 0);
            byp   = BYP && empty && !peff && mdu_valid;
            popv  = !peff && !empty;
            rdy   = (q.size() < DEPTH);
            pushv = mdu_valid && rdy && !byp;
            e_we = 0; e_a = last_a; e_d = last_d;
            if (peff) begin
                e_we = 1; e_a = pipe_waddr; e_d = pipe_wdata;
            end else if (popv) begin
                if (q[0].a != 0) begin e_we = 1; e_a = q[0].a; e_d = q[0].d; end
            end else if (byp && mdu_waddr != 0) begin
                e_we = 1; e_a = mdu_waddr; e_d = mdu_wdata;
            end
            e_stall = m_pend[chk_rs] || m_pend[chk_rt] || m_pend[chk_rd] || forced;
            #1;
            chk($sformatf("rnd%0d rf_we", c),    32'(rf_we),     32'(e_we));
            chk($sformatf("rnd%0d rf_waddr", c), 32'(rf_waddr),  32'(e_a));
            chk($sformatf("rnd%0d rf_wdata", c), rf_wdata,       e_d);
            chk($sformatf("rnd%0d mdu_ready", c),32'(mdu_ready), 32'(rdy));
            chk($sformatf("rnd%0d stall", c),    32'(stall),     32'(e_stall));
            chk($sformatf("rnd%0d pending", c),  pending,        m_pend);
            if (e_we) begin last_a = e_a; last_d = e_d; end
            if (popv) begin m_pend[q[0].a] = 0; void'(q.pop_front()); end
            if (byp) m_pend[mdu_waddr] = 0;
            if (pushv) begin e.a = mdu_waddr; e.d = mdu_wdata; q.push_back(e); end
            if (issue_mdu && issue_rd != 0) m_pend[issue_rd] = 1;
            m_pend[0] = 0;
            if (q.size() == 0 || popv) begin
                losses = 0; forced = 0;
            end else if (!empty && peff) begin
                losses++;
                if (losses >= STARVE) forced = 1;
            end
        end
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("reset rf_we", 32'(rf_we), 32'd0);
        chk("reset ready", 32'(mdu_ready), 32'd1);
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset pending", pending, 32'h0);
        if (!BYP) run_table();
        seq_async_reset();
        seq_starve();
        seq_full();
        run_random(3000);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
